ram_latency_model: RTL and testbench
====================================

Name: ram_latency_model

Overview:
- Word-addressed, single-port main-memory model with a programmable access latency.
- Sits directly downstream of the coherence/arbitration memory controller and consumes its ramaddr/ramstore/ramREN/ramWEN requests.
- Reports progress on ramstate (FREE/BUSY/ACCESS/ERROR) and returns read data on ramload.
- A zero-latency debug port lets the testbench preload memory and dump it.

Parameters:
- LAT, 2: BUSY cycles inserted before the single ACCESS cycle (0 allowed).
- DEPTH, 16384: number of 32-bit words. Valid byte addresses are 0 .. 4*DEPTH-1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ramaddr  in  32  byte address; bits [1:0] ignored.
- ramstore  in  32  write data.
- ramREN  in  1  read request, level-held until ACCESS.
- ramWEN  in  1  write request, level-held until ACCESS.
- ramload  out  32  read data; valid only in an ACCESS cycle of a read.
- ramstate  out  2  ramstate_t from cpu_types_pkg: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- dbgEN  in  1  debug access strobe.
- dbgWEN  in  1  debug write select (1 = write, 0 = read).
- dbgaddr  in  32  debug byte address.
- dbgstore  in  32  debug write data.
- dbgload  out  32  debug read data, combinational from dbgaddr.
- dbgack  out  1  debug access accepted this cycle.

Behaviour:
- Registered state:
  - cnt: width clog2(LAT+1), minimum 1 bit.
  - pend: 1 bit.
  - paddr: 30 bits.
  - pop: 1 bit, 1 = write.
  - mem: DEPTH x 32. Memory contents are NOT cleared by RST.
- Definitions:
  - req = ramREN ^ ramWEN
  - op = ramWEN
  - match = pend && paddr == ramaddr[31:2] && pop == op
  - oor = ramaddr[31:2] >= DEPTH
- ramstate, priority order:
  - ramREN && ramWEN -> ERROR.
  - req && oor -> ERROR.
  - !req -> FREE.
  - req && !match: ACCESS if LAT==0, else BUSY.
  - req && match: ACCESS if cnt==0, else BUSY.
- Counter and pending-request tracking:
  - New request (req && !match && LAT>0): pend<=1, paddr/pop latched, cnt<=LAT-1.
  - Matching request in BUSY: cnt<=cnt-1.
  - ACCESS cycle: pend<=0, so a request still held afterwards is treated as new and pays LAT again.
  - FREE or ERROR: pend<=0, cnt<=0.
- Latency: each access occupies exactly LAT BUSY cycles followed by one ACCESS cycle, i.e. LAT+1 cycles. With LAT=0, every request cycle is ACCESS (back-to-back words).
- Address or op change while BUSY: treated as a new request and the count restarts. No write occurs for the abandoned request.
- Read: in the ACCESS cycle, ramload = mem[ramaddr[31:2]] combinationally; in all other cycles ramload = 0.
- Write: mem[ramaddr[31:2]] <= ramstore at the posedge ending the ACCESS cycle. No write in BUSY, FREE or ERROR.
- Read-after-write: a read ACCESS in the cycle after a write ACCESS to the same word returns the new data.
- Debug port:
  - dbgack = dbgEN && !req && !(ramREN && ramWEN) && dbgaddr[31:2] < DEPTH.
  - Debug write on posedge when dbgack && dbgWEN.
  - dbgload = mem[dbgaddr[31:2]] when dbgaddr is in range, else 0. Independent of dbgEN.
  - A debug access during an active request is ignored (dbgack=0).
- Reset (RST high at posedge):
  - cnt<=0, pend<=0, paddr<=0, pop<=0.
  - Any in-flight write is discarded.
  - No mem write that cycle, debug writes included.
  - ramstate and ramload are combinational: with no request after reset they read FREE and 0.
  - A request held through reset restarts the full LAT count on the first cycle after RST falls.

Test Plan:
- Reset/idle: RST 1 cycle, no requests -> ramstate=FREE, ramload=0. Debug read of an unwritten word has no defined value and is not checked.
- Timed write (LAT=2): ramWEN, addr 0x100, data 0xDEADBEEF held -> BUSY, BUSY, ACCESS. A following read of 0x100 -> BUSY, BUSY, ACCESS with ramload=0xDEADBEEF. dbgload at 0x100 = 0xDEADBEEF.
- Two-word burst as issued by the controller: ramREN held, addr 0x200 then 0x204 immediately after ACCESS -> two full 3-cycle sequences, each ACCESS returning the preloaded words 0x11111111 and 0x22222222.
- Mid-wait change: ramWEN to 0x40 for 1 BUSY cycle, then addr 0x44 -> count restarts (BUSY, BUSY, ACCESS). mem[0x40] is unchanged; mem[0x44] is written.
- Errors: ramREN && ramWEN -> ERROR, no write. Read of addr 4*DEPTH -> ERROR, ramload=0. Dropping the request -> FREE next cycle.
- Reset mid-operation and LAT=0: RST asserted during BUSY of a write -> no write, and the held request pays the full LAT again. With LAT=0, ramREN held over 0x0, 0x4, 0x8 -> ACCESS every cycle with the correct words. dbgEN during a request -> dbgack=0, mem unchanged.

Source files
------------

// File: rtl/ram_latency_model.sv
// rtl/ram_latency_model.sv - word-addressed main-memory model with programmable access latency
module ram_latency_model #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  input  logic        dbgEN,
  input  logic        dbgWEN,
  input  logic [31:0] dbgaddr,
  input  logic [31:0] dbgstore,
  output logic [31:0] dbgload,
  output logic        dbgack
);

  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Encoding matches ramstate_t of the CPU types package.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  logic [CW-1:0] cnt;
  logic          pend;
  logic [29:0]   paddr;
  logic          pop;
  logic [31:0]   mem [DEPTH];

  ramstate_t     state;
  logic          req;
  logic          op;
  logic          both;
  logic          match;
  logic          oor;
  logic          dbg_in;
  logic [AW-1:0] widx;
  logic [AW-1:0] didx;
  logic          unused_addr_lsbs;

  assign req    = ramREN ^ ramWEN;
  assign op     = ramWEN;
  assign both   = ramREN && ramWEN;
  assign match  = pend && (paddr == ramaddr[31:2]) && (pop == op);
  assign oor    = {2'b00, ramaddr[31:2]} >= 32'(DEPTH);
  assign dbg_in = {2'b00, dbgaddr[31:2]} < 32'(DEPTH);
  assign widx   = ramaddr[AW+1:2];
  assign didx   = dbgaddr[AW+1:2];

  // Byte-offset bits are meaningless for a word memory.
  assign unused_addr_lsbs = ^{ramaddr[1:0], dbgaddr[1:0]};

  // Request classification: errors first, then idle, then latency progress.
  always_comb begin
    state = FREE;
    if (both) begin
      state = ERROR;
    end else if (req && oor) begin
      state = ERROR;
    end else if (!req) begin
      state = FREE;
    end else if (!match) begin
      state = (LAT == 0) ? ACCESS : BUSY;
    end else begin
      state = (cnt == '0) ? ACCESS : BUSY;
    end
  end

  assign ramstate = state;
  assign ramload  = (state == ACCESS && !op) ? mem[widx] : 32'h0;
  assign dbgack   = dbgEN && !req && !both && dbg_in;
  assign dbgload  = dbg_in ? mem[didx] : 32'h0;

  // Pending-request tracker: latch a new request, count down while it is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      pend  <= 1'b0;
      paddr <= '0;
      pop   <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (!match) begin
            pend  <= 1'b1;
            paddr <= ramaddr[31:2];
            pop   <= op;
            cnt   <= CW'(LAT - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ACCESS: begin
          pend <= 1'b0;
          cnt  <= '0;
        end
        default: begin
          pend <= 1'b0;
          cnt  <= '0;
        end
      endcase
    end
  end

  // Memory array: bus writes in ACCESS, debug writes only when the bus is idle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == ACCESS && op) begin
        mem[widx] <= ramstore;
      end else if (dbgack && dbgWEN) begin
        mem[didx] <= dbgstore;
      end
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// tb/tb_ram_latency_model.sv - scoreboard bench for ram_latency_model at LAT=2 and LAT=0
module tb_ram_latency_model;

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] addr, store;
  logic        ren2, wen2, ren0, wen0;
  logic        dbgEN, dbgWEN;
  logic [31:0] dbgaddr, dbgstore;
  logic [31:0] load2, load0, dload2, dload0;
  logic [1:0]  state2, state0;
  logic        dack2, dack0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sel;
    logic [1:0]  st;
    logic [31:0] ld;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  ram_latency_model #(.LAT(2), .DEPTH(16384)) u_lat2 (
    .CLK(CLK), .RST(RST), .ramaddr(addr), .ramstore(store),
    .ramREN(ren2), .ramWEN(wen2), .ramload(load2), .ramstate(state2),
    .dbgEN(dbgEN), .dbgWEN(dbgWEN), .dbgaddr(dbgaddr), .dbgstore(dbgstore),
    .dbgload(dload2), .dbgack(dack2)
  );

  ram_latency_model #(.LAT(0), .DEPTH(256)) u_lat0 (
    .CLK(CLK), .RST(RST), .ramaddr(addr), .ramstore(store),
    .ramREN(ren0), .ramWEN(wen0), .ramload(load0), .ramstate(state0),
    .dbgEN(dbgEN), .dbgWEN(dbgWEN), .dbgaddr(dbgaddr), .dbgstore(dbgstore),
    .dbgload(dload0), .dbgack(dack0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One bus cycle: push expectation, compare at negedge, advance past next posedge.
  task automatic cyc(input string tag, input bit sel, input logic [1:0] st, input logic [31:0] ld);
    exp_t e;
    e.sel = sel; e.st = st; e.ld = ld; e.tag = tag;
    sb.push_back(e);
    @(negedge CLK);
    e = sb.pop_front();
    if (e.sel) begin
      chk({e.tag, "_st"}, 32'(state0), 32'(e.st));
      chk({e.tag, "_ld"}, load0, e.ld);
    end else begin
      chk({e.tag, "_st"}, 32'(state2), 32'(e.st));
      chk({e.tag, "_ld"}, load2, e.ld);
    end
    @(posedge CLK); #1;
  endtask

  task automatic bus(input logic r2, input logic w2, input logic [31:0] a, input logic [31:0] d);
    ren2 = r2; wen2 = w2; addr = a; store = d;
  endtask

  task automatic dbg_wr(input logic [31:0] a, input logic [31:0] d);
    dbgEN = 1'b1; dbgWEN = 1'b1; dbgaddr = a; dbgstore = d;
    @(negedge CLK);
    chk("dbg_wr_ack", 32'(dack2), 32'd1);
    @(posedge CLK); #1;
    dbgEN = 1'b0; dbgWEN = 1'b0;
  endtask

  task automatic dbg_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    dbgaddr = a;
    #1;
    chk(tag, dload2, exp);
  endtask

  initial begin
    RST = 1'b1;
    bus(0, 0, 32'h0, 32'h0);
    ren0 = 1'b0; wen0 = 1'b0;
    dbgEN = 1'b0; dbgWEN = 1'b0; dbgaddr = 32'h0; dbgstore = 32'h0;
    @(posedge CLK); #1;
    RST = 1'b0;

    cyc("rst_idle2", 0, S_FREE, 32'h0);
    cyc("rst_idle0", 1, S_FREE, 32'h0);

    dbg_wr(32'h200, 32'h11111111);
    dbg_wr(32'h204, 32'h22222222);
    dbg_wr(32'h40,  32'h40404040);
    dbg_wr(32'h80,  32'h0BADF00D);
    dbg_wr(32'h0,   32'hA0A0A0A0);
    dbg_wr(32'h4,   32'hA1A1A1A1);
    dbg_wr(32'h8,   32'hA2A2A2A2);

    bus(0, 1, 32'h100, 32'hDEADBEEF);
    cyc("wr_b1", 0, S_BUSY, 32'h0);
    cyc("wr_b2", 0, S_BUSY, 32'h0);
    cyc("wr_acc", 0, S_ACC, 32'h0);
    bus(0, 0, 32'h0, 32'h0);
    cyc("wr_free", 0, S_FREE, 32'h0);
    bus(1, 0, 32'h100, 32'h0);
    cyc("rd_b1", 0, S_BUSY, 32'h0);
    cyc("rd_b2", 0, S_BUSY, 32'h0);
    cyc("rd_acc", 0, S_ACC, 32'hDEADBEEF);
    bus(0, 0, 32'h0, 32'h0);
    dbg_chk("dbg_100", 32'h100, 32'hDEADBEEF);

    bus(1, 0, 32'h200, 32'h0);
    cyc("bst0_b1", 0, S_BUSY, 32'h0);
    cyc("bst0_b2", 0, S_BUSY, 32'h0);
    cyc("bst0_acc", 0, S_ACC, 32'h11111111);
    bus(1, 0, 32'h204, 32'h0);
    cyc("bst1_b1", 0, S_BUSY, 32'h0);
    cyc("bst1_b2", 0, S_BUSY, 32'h0);
    cyc("bst1_acc", 0, S_ACC, 32'h22222222);
    bus(0, 0, 32'h0, 32'h0);
    cyc("bst_free", 0, S_FREE, 32'h0);

    bus(0, 1, 32'h40, 32'hCAFE0001);
    cyc("chg_b0", 0, S_BUSY, 32'h0);
    bus(0, 1, 32'h44, 32'hCAFE0001);
    cyc("chg_b1", 0, S_BUSY, 32'h0);
    cyc("chg_b2", 0, S_BUSY, 32'h0);
    cyc("chg_acc", 0, S_ACC, 32'h0);
    bus(0, 0, 32'h0, 32'h0);
    dbg_chk("chg_m40", 32'h40, 32'h40404040);
    dbg_chk("chg_m44", 32'h44, 32'hCAFE0001);

    bus(1, 1, 32'h40, 32'h99999999);
    cyc("err_both", 0, S_ERR, 32'h0);
    cyc("err_both2", 0, S_ERR, 32'h0);
    bus(0, 0, 32'h0, 32'h0);
    cyc("err_free", 0, S_FREE, 32'h0);
    dbg_chk("err_m40", 32'h40, 32'h40404040);
    bus(1, 0, 32'h10000, 32'h0);
    cyc("oor", 0, S_ERR, 32'h0);
    bus(0, 0, 32'h0, 32'h0);
    cyc("oor_free", 0, S_FREE, 32'h0);
    bus(1, 0, 32'hFFFC, 32'h0);
    cyc("last_b1", 0, S_BUSY, 32'h0);
    bus(0, 0, 32'h0, 32'h0);

    dbgaddr = 32'h80;
    bus(0, 1, 32'h80, 32'h12345678);
    cyc("rstm_b0", 0, S_BUSY, 32'h0);
    RST = 1'b1;
    cyc("rstm_rst", 0, S_BUSY, 32'h0);
    RST = 1'b0;
    cyc("rstm_b1", 0, S_BUSY, 32'h0);
    dbg_chk("rstm_nowr", 32'h80, 32'h0BADF00D);
    cyc("rstm_b2", 0, S_BUSY, 32'h0);
    cyc("rstm_acc", 0, S_ACC, 32'h0);
    bus(0, 0, 32'h0, 32'h0);
    dbg_chk("rstm_wr", 32'h80, 32'h12345678);

    bus(1, 0, 32'h200, 32'h0);
    dbgEN = 1'b1; dbgWEN = 1'b1; dbgaddr = 32'h204; dbgstore = 32'hFFFFFFFF;
    @(negedge CLK);
    chk("dbg_busy_ack", 32'(dack2), 32'd0);
    @(posedge CLK); #1;
    cyc("dbgb_b2", 0, S_BUSY, 32'h0);
    cyc("dbgb_acc", 0, S_ACC, 32'h11111111);
    dbgEN = 1'b0; dbgWEN = 1'b0;
    bus(0, 0, 32'h0, 32'h0);
    dbg_chk("dbgb_m204", 32'h204, 32'h22222222);

    ren0 = 1'b1; addr = 32'h0;
    cyc("l0_w0", 1, S_ACC, 32'hA0A0A0A0);
    addr = 32'h4;
    cyc("l0_w1", 1, S_ACC, 32'hA1A1A1A1);
    addr = 32'h8;
    cyc("l0_w2", 1, S_ACC, 32'hA2A2A2A2);
    ren0 = 1'b0; wen0 = 1'b1; addr = 32'hC; store = 32'h55AA55AA;
    cyc("l0_wr", 1, S_ACC, 32'h0);
    wen0 = 1'b0; ren0 = 1'b1;
    cyc("l0_raw", 1, S_ACC, 32'h55AA55AA);
    ren0 = 1'b0;
    cyc("l0_free", 1, S_FREE, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
